// File: rtl/dyn_forwarding_scoreboard_if.sv
// ----------------------------------------------------------------------------
// dyn_forwarding_scoreboard_if
//   Bundles the issue, writeback, bypass-bus and operand-read signals of the
//   forwarding scoreboard. The master side is the pipeline (issue/decode, the
//   bypass network and writeback). The slave side is the scoreboard itself.
//
//   Signals (direction as seen by the slave):
//     flush_i        in   pipeline flush; clears all pending state
//     issue_valid_i  in   [PIPE_NUM]                  destination issued per pipe
//     issue_addr_i   in   [PIPE_NUM*AW]               issued destination register
//     wb_valid_i     in   [PIPE_NUM]                  destination retired per pipe
//     wb_addr_i      in   [PIPE_NUM*AW]               retired destination register
//     fwd_valid_i    in   [PIPE_NUM*STAGE_NUM]        bypass slot holds a producer
//     fwd_ready_i    in   [PIPE_NUM*STAGE_NUM]        producer result available
//     fwd_addr_i     in   [PIPE_NUM*STAGE_NUM*AW]     producer destination
//     fwd_data_i     in   [PIPE_NUM*STAGE_NUM*DW]     producer result
//     rd_addr_i      in   [READ_PORTS*AW]             requested operand register
//     rf_data_i      in   [READ_PORTS*DW]             regfile data per read port
//     rd_data_o      out  [READ_PORTS*DW]             resolved operand
//     stall_o        out                              some port is unresolved
//     pending_o      out  [REG_NUM]                   counter[r] != 0
//     err_o          out                              sticky over/underflow flag
//
//   Bypass slots are packed stage-major: slot = stage*PIPE_NUM + pipe.
// ----------------------------------------------------------------------------
interface dyn_forwarding_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGE_NUM  = 3,
    parameter int PIPE_NUM   = 2,
    parameter int READ_PORTS = 4,
    parameter int REG_NUM    = 32
);
    localparam int AW    = $clog2(REG_NUM);
    localparam int SLOTS = PIPE_NUM * STAGE_NUM;

    logic                             flush_i;
    logic [PIPE_NUM-1:0]              issue_valid_i;
    logic [PIPE_NUM*AW-1:0]           issue_addr_i;
    logic [PIPE_NUM-1:0]              wb_valid_i;
    logic [PIPE_NUM*AW-1:0]           wb_addr_i;
    logic [SLOTS-1:0]                 fwd_valid_i;
    logic [SLOTS-1:0]                 fwd_ready_i;
    logic [SLOTS*AW-1:0]              fwd_addr_i;
    logic [SLOTS*DATA_WIDTH-1:0]      fwd_data_i;
    logic [READ_PORTS*AW-1:0]         rd_addr_i;
    logic [READ_PORTS*DATA_WIDTH-1:0] rf_data_i;
    logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_o;
    logic                             stall_o;
    logic [REG_NUM-1:0]               pending_o;
    logic                             err_o;

    modport master (
        output flush_i, issue_valid_i, issue_addr_i, wb_valid_i, wb_addr_i,
               fwd_valid_i, fwd_ready_i, fwd_addr_i, fwd_data_i,
               rd_addr_i, rf_data_i,
        input  rd_data_o, stall_o, pending_o, err_o
    );

    modport slave (
        input  flush_i, issue_valid_i, issue_addr_i, wb_valid_i, wb_addr_i,
               fwd_valid_i, fwd_ready_i, fwd_addr_i, fwd_data_i,
               rd_addr_i, rf_data_i,
        output rd_data_o, stall_o, pending_o, err_o
    );
endinterface

// File: rtl/dyn_forwarding_scoreboard.sv
// ----------------------------------------------------------------------------
// dyn_forwarding_scoreboard
//   Operand forwarding with a per-register pending-write scoreboard. Each read
//   port takes the youngest matching bypass producer if its result is ready.
//   It stalls if that producer is not ready, or if the register still has an
//   outstanding write that is not yet on the bus. Otherwise it takes the
//   regfile data.
//
//   Ports:
//     clk   in  clock
//     rst   in  synchronous active-high reset (clears counters and err)
//     sb    slave modport of dyn_forwarding_scoreboard_if (see that file)
//
//   Register 0 is never tracked and always reads as zero without stalling.
// ----------------------------------------------------------------------------
module dyn_forwarding_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGE_NUM  = 3,
    parameter int PIPE_NUM   = 2,
    parameter int READ_PORTS = 4,
    parameter int REG_NUM    = 32,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    dyn_forwarding_scoreboard_if.slave sb
);
    localparam int AW = $clog2(REG_NUM);
    // Signed width wide enough for cnt + PIPE_NUM and for cnt - PIPE_NUM.
    localparam int SW = CNT_WIDTH + $clog2(PIPE_NUM + 1) + 2;
    localparam logic signed [SW-1:0] CNT_MAX = SW'((2 ** CNT_WIDTH) - 1);

    logic [CNT_WIDTH-1:0] r_cnt [REG_NUM];
    logic                 r_err;

    logic [CNT_WIDTH-1:0]             w_next_cnt [REG_NUM];
    logic                             w_ovf;
    logic                             w_udf;
    logic [READ_PORTS*DATA_WIDTH-1:0] w_rd_data;
    logic [READ_PORTS-1:0]            w_port_stall;
    logic [REG_NUM-1:0]               w_pending;

    // ------------------------------------------------------------------------
    // Counter next state. The issue and writeback deltas of all pipes are
    // summed first and applied in one step, so an issue and a writeback of the
    // same register in one cycle cancel out. The result then saturates or
    // clamps.
    // ------------------------------------------------------------------------
    always_comb begin
        logic signed [SW-1:0] sum;
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned (which would infer a latch).
        w_ovf = 1'b0;
        w_udf = 1'b0;
        sum   = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            w_next_cnt[r] = '0;
        end
        for (int r = 1; r < REG_NUM; r++) begin
            sum = $signed(SW'(r_cnt[r]));
            for (int p = 0; p < PIPE_NUM; p++) begin
                if (sb.issue_valid_i[p] && sb.issue_addr_i[p*AW +: AW] == AW'(r))
                    sum = sum + SW'(1);
                if (sb.wb_valid_i[p] && sb.wb_addr_i[p*AW +: AW] == AW'(r))
                    sum = sum - SW'(1);
            end
            if (sum[SW-1]) begin
                w_next_cnt[r] = '0;
                w_udf         = 1'b1;
            end else if (sum > CNT_MAX) begin
                w_next_cnt[r] = '1;
                w_ovf         = 1'b1;
            end else begin
                w_next_cnt[r] = sum[CNT_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // State. Flush wins over same-cycle issue/writeback, so events discarded by
    // a flush cannot raise err either. Only rst clears err.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples its pre-edge inputs, whatever the block order.
        if (rst) begin
            // NOTE: the counter array is reset explicitly. Unlike a data RAM,
            // its contents define pending state and must start at zero.
            for (int r = 0; r < REG_NUM; r++) r_cnt[r] <= '0;
            r_err <= 1'b0;
        end else if (sb.flush_i) begin
            for (int r = 0; r < REG_NUM; r++) r_cnt[r] <= '0;
        end else begin
            r_cnt <= w_next_cnt;
            r_err <= r_err | w_ovf | w_udf;
        end
    end

    // ------------------------------------------------------------------------
    // Operand resolution. Only the registered counters are used, so an issue
    // in this cycle is not seen by a read in the same cycle. The scan runs
    // youngest first (stage 0 upward, higher pipe first within a stage). The
    // first address match wins even if it is not ready, because an older
    // ready value would be stale.
    // ------------------------------------------------------------------------
    always_comb begin
        logic                  hit;
        logic                  hit_rdy;
        logic [DATA_WIDTH-1:0] hit_data;
        logic [AW-1:0]         ra;
        int                    slot;
        w_rd_data    = '0;
        w_port_stall = '0;
        hit          = 1'b0;
        hit_rdy      = 1'b0;
        hit_data     = '0;
        ra           = '0;
        slot         = 0;
        for (int rp = 0; rp < READ_PORTS; rp++) begin
            ra       = sb.rd_addr_i[rp*AW +: AW];
            hit      = 1'b0;
            hit_rdy  = 1'b0;
            hit_data = '0;
            for (int s = 0; s < STAGE_NUM; s++) begin
                for (int p = PIPE_NUM - 1; p >= 0; p--) begin
                    slot = s * PIPE_NUM + p;
                    if (!hit && sb.fwd_valid_i[slot] &&
                        sb.fwd_addr_i[slot*AW +: AW] == ra) begin
                        hit      = 1'b1;
                        hit_rdy  = sb.fwd_ready_i[slot];
                        hit_data = sb.fwd_data_i[slot*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            if (ra == '0) begin
                w_rd_data[rp*DATA_WIDTH +: DATA_WIDTH] = '0;
                w_port_stall[rp]                       = 1'b0;
            end else if (hit) begin
                w_rd_data[rp*DATA_WIDTH +: DATA_WIDTH] = hit_data;
                w_port_stall[rp]                       = !hit_rdy;
            end else begin
                w_rd_data[rp*DATA_WIDTH +: DATA_WIDTH] =
                    sb.rf_data_i[rp*DATA_WIDTH +: DATA_WIDTH];
                w_port_stall[rp] = (r_cnt[ra] != '0);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            w_pending[r] = (r_cnt[r] != '0);
        end
    end

    assign sb.rd_data_o = w_rd_data;
    assign sb.stall_o   = |w_port_stall;
    assign sb.pending_o = w_pending;
    assign sb.err_o     = r_err;

endmodule

// File: tb/tb_dyn_forwarding_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_dyn_forwarding_scoreboard
//   Directed bench for dyn_forwarding_scoreboard with CNT_WIDTH=2, so that the
//   overflow case can be reached. Inputs change 1 ns after the rising edge.
//   Outputs are sampled 1 ns after each input change, away from the edge.
// ----------------------------------------------------------------------------
module tb_dyn_forwarding_scoreboard;
    localparam int DW = 32;
    localparam int S  = 3;
    localparam int P  = 2;
    localparam int RP = 4;
    localparam int RN = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dyn_forwarding_scoreboard_if #(
        .DATA_WIDTH(DW), .STAGE_NUM(S), .PIPE_NUM(P), .READ_PORTS(RP), .REG_NUM(RN)
    ) bus ();

    dyn_forwarding_scoreboard #(
        .DATA_WIDTH(DW), .STAGE_NUM(S), .PIPE_NUM(P), .READ_PORTS(RP),
        .REG_NUM(RN), .CNT_WIDTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; one-cycle pulses (issue, wb, flush) drop afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        bus.issue_valid_i = '0;
        bus.wb_valid_i    = '0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic clear_fwd();
        bus.fwd_valid_i = '0;
        bus.fwd_ready_i = '0;
        bus.fwd_addr_i  = '0;
        bus.fwd_data_i  = '0;
    endtask

    task automatic clear_rd();
        bus.rd_addr_i = '0;
        bus.rf_data_i = '0;
    endtask

    task automatic set_slot(input int s, input int p, input logic [AW-1:0] a,
                            input logic rdy, input logic [DW-1:0] d);
        int k;
        k = s * P + p;
        bus.fwd_valid_i[k]         = 1'b1;
        bus.fwd_ready_i[k]         = rdy;
        bus.fwd_addr_i[k*AW +: AW] = a;
        bus.fwd_data_i[k*DW +: DW] = d;
    endtask

    task automatic set_rd(input int port, input logic [AW-1:0] a, input logic [DW-1:0] rf);
        bus.rd_addr_i[port*AW +: AW] = a;
        bus.rf_data_i[port*DW +: DW] = rf;
    endtask

    task automatic do_issue(input int p, input logic [AW-1:0] a);
        bus.issue_valid_i[p]         = 1'b1;
        bus.issue_addr_i[p*AW +: AW] = a;
    endtask

    task automatic do_wb(input int p, input logic [AW-1:0] a);
        bus.wb_valid_i[p]         = 1'b1;
        bus.wb_addr_i[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd(input int port);
        return bus.rd_data_o[port*DW +: DW];
    endfunction

    initial begin
        rst               = 1'b1;
        bus.flush_i       = 1'b0;
        bus.issue_valid_i = '0;
        bus.issue_addr_i  = '0;
        bus.wb_valid_i    = '0;
        bus.wb_addr_i     = '0;
        clear_fwd();
        clear_rd();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and a plain regfile read. Port 1 reads r0 and must
        // return zero, not its regfile data.
        set_rd(0, 5'd5, 32'h11);
        set_rd(1, 5'd0, 32'hDEAD);
        #1;
        check("rst_rd_r5",   rd(0),         32'h11);
        check("rst_rd_r0",   rd(1),         32'h0);
        check("rst_stall",   bus.stall_o,   1'b0);
        check("rst_pending", bus.pending_o, 32'h0);
        check("rst_err",     bus.err_o,     1'b0);

        // Issue r5. A read in the same cycle must not see it yet.
        do_issue(0, 5'd5);
        #1;
        check("issue_same_cycle_stall", bus.stall_o, 1'b0);
        step();
        check("r5_pending", bus.pending_o, 32'h20);
        #1;
        check("r5_bus_empty_stall", bus.stall_o, 1'b1);
        // s1p1 is the youngest match. s1p0 and s2p0 are older ready matches.
        set_slot(2, 0, 5'd5, 1'b1, 32'hBB);
        set_slot(1, 0, 5'd5, 1'b1, 32'hCC);
        set_slot(1, 1, 5'd5, 1'b1, 32'hAA);
        #1;
        check("r5_fwd_data",  rd(0),       32'hAA);
        check("r5_fwd_stall", bus.stall_o, 1'b0);
        clear_fwd();
        do_wb(0, 5'd5);
        step();
        check("r5_retired_pending", bus.pending_o, 32'h0);

        // r7: both pipes issue it in one cycle, so cnt becomes 2.
        clear_rd();
        do_issue(0, 5'd7);
        do_issue(1, 5'd7);
        step();
        check("r7_pending", bus.pending_o, 32'h80);
        set_rd(2, 5'd7, 32'h99);
        set_slot(0, 0, 5'd7, 1'b0, 32'h55);
        set_slot(2, 1, 5'd7, 1'b1, 32'h33);
        #1;
        check("r7_young_not_ready_stall", bus.stall_o, 1'b1);
        set_slot(0, 0, 5'd7, 1'b1, 32'h44);
        #1;
        check("r7_young_ready_data",  rd(2),       32'h44);
        check("r7_young_ready_stall", bus.stall_o, 1'b0);
        clear_fwd();
        set_slot(2, 1, 5'd7, 1'b1, 32'h33);
        #1;
        check("r7_old_ready_data", rd(2), 32'h33);
        clear_fwd();
        #1;
        check("r7_no_bus_stall", bus.stall_o, 1'b1);
        do_wb(0, 5'd7);
        do_wb(1, 5'd7);
        step();
        check("r7_retired_pending", bus.pending_o, 32'h0);
        check("r7_stall_clear",     bus.stall_o,   1'b0);
        check("r7_err",             bus.err_o,     1'b0);

        // r9: issue and writeback in the same cycle cancel out. A dual issue
        // adds 2.
        clear_rd();
        do_issue(0, 5'd9);
        step();                                   // cnt9 = 1
        do_issue(0, 5'd9);
        do_wb(1, 5'd9);
        step();                                   // cnt9 = 1
        check("r9_issue_wb_same", bus.pending_o, 32'h200);
        do_issue(0, 5'd9);
        do_issue(1, 5'd9);
        step();                                   // cnt9 = 3
        do_wb(0, 5'd9);
        do_wb(1, 5'd9);
        step();                                   // cnt9 = 1
        check("r9_after_dual_wb", bus.pending_o, 32'h200);
        do_wb(0, 5'd9);
        step();                                   // cnt9 = 0
        check("r9_drained", bus.pending_o, 32'h0);
        check("r9_err",     bus.err_o,     1'b0);

        // Overflow with 2-bit counters: the 4th issue of r3 saturates.
        repeat (3) begin
            do_issue(0, 5'd3);
            step();
        end
        check("r3_at_max_err", bus.err_o, 1'b0);
        do_issue(0, 5'd3);
        step();
        check("r3_overflow_err", bus.err_o, 1'b1);
        // Underflow: writeback r4 while cnt4 is 0.
        do_wb(0, 5'd4);
        step();
        check("r4_underflow_pending", bus.pending_o, 32'h8);
        check("r4_underflow_err",     bus.err_o,     1'b1);
        // Saturated at 3: three writebacks drain r3 completely.
        repeat (2) begin
            do_wb(0, 5'd3);
            step();
        end
        check("r3_sat_partial", bus.pending_o, 32'h8);
        do_wb(0, 5'd3);
        step();
        check("r3_sat_drained", bus.pending_o, 32'h0);

        // Flush clears pending state and drops a same-cycle issue. err stays.
        do_issue(0, 5'd3);
        do_issue(1, 5'd4);
        step();
        check("flush_pre_pending", bus.pending_o, 32'h18);
        bus.flush_i = 1'b1;
        do_issue(0, 5'd6);
        step();
        check("flush_pending",  bus.pending_o, 32'h0);
        check("flush_keep_err", bus.err_o,     1'b1);
        set_rd(0, 5'd0, 32'h77);
        set_rd(1, 5'd3, 32'h1234);
        set_slot(0, 0, 5'd0, 1'b0, 32'h99);
        #1;
        check("r0_data",      rd(0),       32'h0);
        check("r3_rf_data",   rd(1),       32'h1234);
        check("r0_stall",     bus.stall_o, 1'b0);
        clear_fwd();
        do_issue(0, 5'd0);
        step();
        check("r0_untracked", bus.pending_o, 32'h0);

        // Only rst clears err.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_clears_err", bus.err_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
